// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side handshake between the TX FIFO and uart_tx_serializer.
// master = serializer (issues pops), slave = FIFO (supplies data/empty).
interface uart_tx_serializer_if #(
  parameter int data_wd = 8
);
  logic               empty;
  logic [data_wd-1:0] rd_data;
  logic               rd_en;

  modport master (input empty, input rd_data, output rd_en);
  modport slave  (output empty, output rd_data, input rd_en);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one FIFO word per frame and shifts it out LSB first.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int data_wd   = 8,
  parameter int stop_bits = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_en,
  input  logic [15:0]                 baud_div,
  input  logic                        parity_odd,
  uart_tx_serializer_if.master        fifo,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int BIT_W = (data_wd > 1) ? $clog2(data_wd) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(data_wd - 1);
  localparam logic             LAST_STOP = (stop_bits == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               tx_q, tx_d;
  logic [data_wd-1:0] shreg_q, shreg_d;
  logic [15:0]        div_q, div_d;
  logic               rd_en_c;
  logic               frame_done_c;
  logic               bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign bit_end = (baud_cnt_q == div_q);

  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shreg_d      = shreg_q;
    div_d        = div_q;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    rd_en_c      = 1'b0;
    frame_done_c = 1'b0;
    tx_d         = 1'b1;

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        if (tx_en && !fifo.empty) begin
          rd_en_c = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Word and divisor are frozen here so later FIFO/register changes cannot disturb the frame
        shreg_d    = fifo.rd_data;
        div_d      = baud_div;
        baud_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d      = (^fifo.rd_data) ^ parity_odd;
`endif
        state_d    = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == LAST_STOP) begin
            frame_done_c = 1'b1;
            stop_cnt_d   = 1'b0;
            state_d      = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && state_q != S_FETCH) begin
      baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
    end

    // Line level is computed for the upcoming state so tx comes straight off a flop
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    div_q   <= div_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  // Pops are held off while rst is high so no word is lost to a held reset
  assign fifo.rd_en = rd_en_c && !rst;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_c;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a small queue-based FIFO model.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        parity_odd = 1'b0;
  logic        tx, busy, frame_done;

  uart_tx_serializer_if #(.data_wd(8)) fif();

  uart_tx_serializer #(.data_wd(8), .stop_bits(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .parity_odd (parity_odd),
    .fifo       (fif),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pops = 0;
  int         bad_pops = 0;
  logic       tx_s, busy_s, fd_s, rd_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: pop decision taken at negedge, FIFO updated and outputs sampled after the edge
  task automatic tick();
    logic pop;
    @(negedge clk);
    pop = fif.rd_en;
    if (pop && (busy || fif.empty)) bad_pops++;
    @(posedge clk);
    #1;
    if (pop) begin
      pops++;
      if (fifo_q.size() > 0) fif.rd_data = fifo_q.pop_front();
    end
    fif.empty = (fifo_q.size() == 0);
    #1;
    tx_s   = tx;
    busy_s = busy;
    fd_s   = frame_done;
    rd_s   = fif.rd_en;
  endtask

  task automatic wait_start(input string tag, output int n);
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 300) begin
      tick();
      n++;
      if (tx_s == 1'b0 && busy_s) found = 1'b1;
    end
    if (!found) check({tag, "_start_timeout"}, {63'd0, found}, 64'd1);
  endtask

  // Current sample is the first START clock; records the line for len clocks
  task automatic capture(input int len, input int change_at, output logic [63:0] pat, output int fd_off);
    pat = '0;
    fd_off = -1;
    for (int i = 0; i < len; i++) begin
      if (i > 0) tick();
      pat[i] = tx_s;
      if (fd_s && fd_off < 0) fd_off = i;
      if (i == change_at) begin
        baud_div = 16'd9;
        tx_en    = 1'b0;
        fifo_q.push_back(8'h3C);
      end
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [7:0] d, input logic par, input int bd);
    logic [11:0] bits;
    logic [63:0] p;
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
`ifdef UART_TX_PARITY_EN
    bits[9] = par;
`else
    bits[9] = 1'b1 | par;
`endif
    p = '0;
    for (int i = 0; i < NB * (bd + 1); i++) p[i] = bits[i / (bd + 1)];
    return p;
  endfunction

  task automatic send_one(input string tag, input logic [7:0] d, input logic par, input int bd);
    logic [63:0] pat;
    int fd_off, n, p0;
    p0 = pops;
    baud_div = 16'(bd);
    fifo_q.push_back(d);
    wait_start(tag, n);
    capture(NB * (bd + 1), -1, pat, fd_off);
    check({tag, "_pattern"}, pat, exp_frame(d, par, bd));
    check({tag, "_done_at"}, 64'(fd_off), 64'(NB * (bd + 1) - 1));
    check({tag, "_pops"}, 64'(pops - p0), 64'd1);
  endtask

  typedef struct { logic [7:0] d; logic odd; logic par; } par_vec_t;
  par_vec_t pvec[4] = '{
    '{8'h07, 1'b0, 1'b1},
    '{8'h07, 1'b1, 1'b0},
    '{8'h03, 1'b0, 1'b0},
    '{8'h03, 1'b1, 1'b1}
  };

  initial begin
    logic [63:0] pat;
    int fd_off, n, p0;

    fif.empty   = 1'b1;
    fif.rd_data = 8'h00;

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", {63'd0, tx_s}, 64'd1);
      check("rst_busy", {63'd0, busy_s}, 64'd0);
      check("rst_rd_en", {63'd0, rd_s}, 64'd0);
    end
    rst   = 1'b0;
    tx_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("idle_busy", {63'd0, busy_s}, 64'd0);
    check("idle_tx", {63'd0, tx_s}, 64'd1);
    check("idle_pops", 64'(pops), 64'd0);

    // Single frame A5, 4 clocks/bit: line 0, 1,0,1,0,0,1,0,1, [parity 0], 1
    send_one("a5", 8'hA5, 1'b0, 3);
    tick();
    tick();
    check("a5_busy_after", {63'd0, busy_s}, 64'd0);

    // Back-to-back 00 then FF
    p0 = pops;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    wait_start("b2b1", n);
    capture(NB * 4, -1, pat, fd_off);
    check("b2b1_pattern", pat, exp_frame(8'h00, 1'b0, 3));
    check("b2b1_done_at", 64'(fd_off), 64'(NB * 4 - 1));
    wait_start("b2b2", n);
    check("b2b_gap", 64'(n), 64'd3);
    capture(NB * 4, -1, pat, fd_off);
    check("b2b2_pattern", pat, exp_frame(8'hFF, 1'b0, 3));
    for (int i = 0; i < 20; i++) tick();
    check("b2b_pops", 64'(pops - p0), 64'd2);
    check("b2b_idle", {63'd0, busy_s}, 64'd0);

    // One clock per bit
    send_one("div0", 8'h81, 1'b0, 0);

    // Parity vectors (parity column only matters with the parity bit enabled)
    for (int v = 0; v < 4; v++) begin
      parity_odd = pvec[v].odd;
      send_one($sformatf("par%0d", v), pvec[v].d, pvec[v].par, 1);
    end
    parity_odd = 1'b0;

    // Divisor and tx_en change during DATA bit 2; frame keeps 4-clock bits
    p0 = pops;
    baud_div = 16'd3;
    fifo_q.push_back(8'h5A);
    wait_start("mid", n);
    capture(NB * 4, 13, pat, fd_off);
    check("mid_pattern", pat, exp_frame(8'h5A, 1'b0, 3));
    check("mid_done_at", 64'(fd_off), 64'(NB * 4 - 1));
    for (int i = 0; i < 30; i++) tick();
    check("mid_pops", 64'(pops - p0), 64'd1);
    check("mid_busy", {63'd0, busy_s}, 64'd0);
    check("mid_tx", {63'd0, tx_s}, 64'd1);

    // Reset during DATA bit 4 of the 3C frame, then 96 goes out fresh
    p0 = pops;
    baud_div = 16'd3;
    tx_en = 1'b1;
    fifo_q.push_back(8'h96);
    wait_start("rstmid", n);
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b1;
    tick();
    check("rstmid_tx", {63'd0, tx_s}, 64'd1);
    check("rstmid_busy", {63'd0, busy_s}, 64'd0);
    check("rstmid_done", {63'd0, fd_s}, 64'd0);
    check("rstmid_rd_en", {63'd0, rd_s}, 64'd0);
    rst = 1'b0;
    wait_start("fresh", n);
    capture(NB * 4, -1, pat, fd_off);
    check("fresh_pattern", pat, exp_frame(8'h96, 1'b0, 3));
    check("fresh_done_at", 64'(fd_off), 64'(NB * 4 - 1));
    check("fresh_pops", 64'(pops - p0), 64'd2);

    for (int i = 0; i < 10; i++) tick();
    check("no_bad_pops", 64'(bad_pops), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
